sprite_move_gen: RTL

Parametrised, single-clock successor of the player motion engine, one instance per controllable sprite. Reads direction keys and collision reports from the current frame. Once per `startOfFrame`, it:
- rolls back the previous step on any axis that ran into an obstacle,
- applies one single-axis step at the selected speed level,
- clamps the result to the play-field.

It sits between keypad decode and the sprite drawing/collision logic. It also exports facing direction and a moving flag for sprite animation.

---
 rtl/sprite_move_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sprite_move_gen.sv
// Per-sprite motion engine: latches keys/collisions over a frame, then per startOfFrame
// rolls back colliding steps, applies one single-axis step and clamps to the play-field.
module sprite_move_gen #(
   parameter int INITIAL_X    = 15,
   parameter int INITIAL_Y    = 48,
   parameter int OBJECT_W     = 32,
   parameter int OBJECT_H     = 32,
   parameter int FRAME_LEFT   = 15,
   parameter int FRAME_RIGHT  = 623,
   parameter int FRAME_TOP    = 48,
   parameter int FRAME_BOTTOM = 464,
   parameter int FRAC_BITS    = 6,
   parameter int SPEED0       = 64,
   parameter int SPEED1       = 96,
   parameter int SPEED2       = 128,
   parameter int SPEED3       = 160
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               game_on,
   input  logic               up_direction_key,
   input  logic               down_direction_key,
   input  logic               left_direction_key,
   input  logic               right_direction_key,
   input  logic               collision,
   input  logic [3:0]         HitEdgeCode,
   input  logic [1:0]         speed_level,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic [1:0]         facing,
   output logic               moving
);

   localparam int W = 11 + FRAC_BITS;
   localparam int ONE = 1 << FRAC_BITS;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_RESOLVE = 3'd2;
   localparam logic [2:0] S_APPLY   = 3'd3;
   localparam logic [2:0] S_LIMIT   = 3'd4;

   localparam logic [1:0] D_DOWN  = 2'b00;
   localparam logic [1:0] D_UP    = 2'b01;
   localparam logic [1:0] D_LEFT  = 2'b10;
   localparam logic [1:0] D_RIGHT = 2'b11;

   localparam logic signed [W-1:0] X_INIT = W'(INITIAL_X * ONE);
   localparam logic signed [W-1:0] Y_INIT = W'(INITIAL_Y * ONE);
   localparam logic signed [W-1:0] X_MIN  = W'(FRAME_LEFT * ONE);
   localparam logic signed [W-1:0] X_MAX  = W'((FRAME_RIGHT - OBJECT_W) * ONE);
   localparam logic signed [W-1:0] Y_MIN  = W'(FRAME_TOP * ONE);
   localparam logic signed [W-1:0] Y_MAX  = W'((FRAME_BOTTOM - OBJECT_H) * ONE);

   logic [2:0]          r_state;
   logic signed [W-1:0] r_x, r_y, r_px, r_py, r_step;
   logic [3:0]          r_keys;   // {up, down, left, right}
   logic [3:0]          r_hit;    // {left, top, right, bottom}
   logic [1:0]          r_facing, r_last_dir;
   logic                r_last_valid, r_moving;

   logic [3:0]          w_keys_now;
   logic signed [W-1:0] w_step;
   logic [1:0]          w_sel_dir;
   logic                w_sel_valid, w_roll_x, w_roll_y, w_clear;

   function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] v,
                                                 input logic signed [W-1:0] lo,
                                                 input logic signed [W-1:0] hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

   assign w_keys_now = {up_direction_key, down_direction_key, left_direction_key, right_direction_key};

   // Only an obstacle on the side we were heading into undoes the last step.
   assign w_roll_x = r_last_valid && ((r_hit[1] && r_last_dir == D_RIGHT) ||
                                      (r_hit[3] && r_last_dir == D_LEFT));
   assign w_roll_y = r_last_valid && ((r_hit[0] && r_last_dir == D_DOWN) ||
                                      (r_hit[2] && r_last_dir == D_UP));

   // Leaving COLLECT because the game stopped returns to spawn immediately.
   assign w_clear = reset || (r_state == S_IDLE) ||
                    (r_state == S_COLLECT && !startOfFrame && !game_on);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_step = W'(SPEED0);
      case (speed_level)
         2'd1:    w_step = W'(SPEED1);
         2'd2:    w_step = W'(SPEED2);
         2'd3:    w_step = W'(SPEED3);
         default: w_step = W'(SPEED0);
      endcase

      w_sel_valid = |r_keys;
      w_sel_dir   = D_DOWN;
      if      (r_keys[3]) w_sel_dir = D_UP;
      else if (r_keys[2]) w_sel_dir = D_DOWN;
      else if (r_keys[1]) w_sel_dir = D_LEFT;
      else if (r_keys[0]) w_sel_dir = D_RIGHT;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_x          <= X_INIT;
         r_y          <= Y_INIT;
         r_px         <= X_INIT;
         r_py         <= Y_INIT;
         r_step       <= '0;
         r_keys       <= '0;
         r_hit        <= '0;
         r_facing     <= D_DOWN;
         r_last_dir   <= D_DOWN;
         r_last_valid <= 1'b0;
         r_moving     <= 1'b0;
         r_state      <= (!reset && r_state == S_IDLE && game_on) ? S_COLLECT : S_IDLE;
      end else begin
         case (r_state)
            S_COLLECT: begin
               r_keys <= r_keys | w_keys_now;
               if (collision) r_hit <= r_hit | HitEdgeCode;
               if (startOfFrame) r_state <= S_RESOLVE;
            end
            S_RESOLVE: begin
               if (w_roll_x) r_x <= r_px;
               if (w_roll_y) r_y <= r_py;
               r_hit   <= '0;
               r_step  <= w_step;
               r_state <= S_APPLY;
            end
            S_APPLY: begin
               r_px <= r_x;
               r_py <= r_y;
               if (w_sel_valid) begin
                  case (w_sel_dir)
                     D_UP:    r_y <= r_y - r_step;
                     D_DOWN:  r_y <= r_y + r_step;
                     D_LEFT:  r_x <= r_x - r_step;
                     default: r_x <= r_x + r_step;
                  endcase
                  r_facing <= w_sel_dir;
               end
               r_last_dir   <= w_sel_dir;
               r_last_valid <= w_sel_valid;
               r_moving     <= w_sel_valid;
               r_keys       <= '0;
               r_state      <= S_LIMIT;
            end
            S_LIMIT: begin
               r_x     <= clamp(r_x, X_MIN, X_MAX);
               r_y     <= clamp(r_y, Y_MIN, Y_MAX);
               r_state <= game_on ? S_COLLECT : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign topLeftX = r_x[W-1:FRAC_BITS];
   assign topLeftY = r_y[W-1:FRAC_BITS];
   assign facing   = r_facing;
   assign moving   = r_moving;

endmodule
